// File: rtl/riscv_arb_mux_pkg.sv
// Shared constants and types for the arbitrated mux.
// XLEN default word width, ARB_N_MAX channel limit, output stage state.
package riscv_arb_mux_pkg;

  localparam int XLEN      = 32;
  localparam int ARB_N_MAX = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr.
// Ports: req[N], ptr -> gnt_idx, gnt_vld (no clock).
module riscv_rr_arbiter
  import riscv_arb_mux_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  if (N < 2 || N > ARB_N_MAX) begin : g_bad_n
    $error("riscv_rr_arbiter: N out of range");
  end

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  int             sum;

  // Rotating the doubled vector puts ptr at bit 0; the lowest
  // set bit among the first N is the offset of the winner.
  always_comb begin
    dbl     = {req, req};
    rot     = dbl >> ptr;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_vld = 1'b1;
        sum     = int'(ptr) + i;
        if (sum >= N) sum = sum - N;
        gnt_idx = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/riscv_arb_mux.sv
// N-channel round-robin mux with valid/ready and one output register.
// Ports: i_clk, i_rst (async high), i_mux_concat_data, i_mux_valid,
// o_mux_ready, o_mux_data, o_mux_valid, i_mux_ready, o_mux_grant_idx.
// Option RISCV_ARB_MUX_LOCK_EN adds i_mux_last for per-packet grants.
module riscv_arb_mux
  import riscv_arb_mux_pkg::*;
#(
  parameter int N_MUX_IN = 2,
  parameter int DATA_W   = XLEN,
  localparam int IW = $clog2(N_MUX_IN)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_MUX_IN*DATA_W-1:0]   i_mux_concat_data,
  input  logic [N_MUX_IN-1:0]          i_mux_valid,
`ifdef RISCV_ARB_MUX_LOCK_EN
  input  logic [N_MUX_IN-1:0]          i_mux_last,
`endif
  output logic [N_MUX_IN-1:0]          o_mux_ready,
  output logic [DATA_W-1:0]            o_mux_data,
  output logic                         o_mux_valid,
  input  logic                         i_mux_ready,
  output logic [IW-1:0]                o_mux_grant_idx
);

  out_state_e          state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       next_ptr;
  logic [IW-1:0]       grant;
  logic                gnt_vld;
  logic                can_accept;
  logic                accept;
  logic                adv;
  logic [N_MUX_IN-1:0] arb_req;
  logic [DATA_W-1:0]   sel_data;

`ifdef RISCV_ARB_MUX_LOCK_EN
  logic          lock_vld;
  logic [IW-1:0] lock_idx;

  // While locked only the owner may compete; its dropped valid
  // simply yields a bubble.
  always_comb begin
    arb_req = i_mux_valid;
    if (lock_vld) begin
      arb_req           = '0;
      arb_req[lock_idx] = i_mux_valid[lock_idx];
    end
  end

  assign adv = i_mux_last[grant];
`else
  assign arb_req = i_mux_valid;
  assign adv     = 1'b1;
`endif

  riscv_rr_arbiter #(
    .N (N_MUX_IN)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt_idx (grant),
    .gnt_vld (gnt_vld)
  );

  assign o_mux_valid = (state == OUT_FULL);
  assign can_accept  = !o_mux_valid || i_mux_ready;
  assign accept      = gnt_vld && can_accept;
  assign sel_data    =
    i_mux_concat_data[DATA_W*int'(grant) +: DATA_W];

  // Explicit wrap keeps non-power-of-2 channel counts in range.
  assign next_ptr = (grant == IW'(N_MUX_IN - 1)) ?
                    '0 : grant + 1'b1;

  always_comb begin
    o_mux_ready = '0;
    if (accept) o_mux_ready[grant] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= OUT_EMPTY;
      o_mux_data      <= '0;
      o_mux_grant_idx <= '0;
      rr_ptr          <= '0;
`ifdef RISCV_ARB_MUX_LOCK_EN
      lock_vld        <= 1'b0;
      lock_idx        <= '0;
`endif
    end else if (accept) begin
      state           <= OUT_FULL;
      o_mux_data      <= sel_data;
      o_mux_grant_idx <= grant;
      if (adv) rr_ptr <= next_ptr;
`ifdef RISCV_ARB_MUX_LOCK_EN
      lock_vld        <= !adv;
      lock_idx        <= grant;
`endif
    end else if (o_mux_valid && i_mux_ready) begin
      state <= OUT_EMPTY;
    end
  end

endmodule
